rtc_calendar_gen2: RTL
======================

// Module: rtc_calendar_gen2
// PURPOSE
//  Parametrised real-time calendar clock that counts sec/min/hrs/day/mon and adds a year.
//  Leap years are computed internally (Gregorian rule), so no external leap input is needed.
//  A clock-cycle prescaler generates the 1 Hz advance. The block also supports validated
//  time/date load and a sticky daily alarm. It sits in the timekeeping subsystem and drives
//  display/scheduler logic.
// PARAMETERS
//  CLK_DIV   50_000_000  clk cycles per second; >=1 (1 = advance every cycle)
//  YEAR_W    12          year counter width
//  YEAR_RST  2000        year value after reset; must fit in YEAR_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  run        in   1       1 = count; 0 = prescaler and all counters frozen
//  load       in   1       1-cycle strobe: request load of ld_* fields
//  ld_year    in   YEAR_W  load year
//  ld_mon     in   4       load month 1..12
//  ld_day     in   5       load day 1..days_in(ld_mon,ld_year)
//  ld_hrs     in   5       load hours 0..23
//  ld_min     in   6       load minutes 0..59
//  ld_sec     in   6       load seconds 0..59
//  load_err   out  1       1-cycle pulse: last load rejected
//  al_set     in   1       strobe: latch al_hrs/al_min/al_sec/al_en
//  al_hrs     in   5       alarm hours
//  al_min     in   6       alarm minutes
//  al_sec     in   6       alarm seconds
//  al_en      in   1       alarm enable (latched on al_set)
//  al_ack     in   1       clears alarm_flag
//  alarm_flag out  1       sticky alarm indication
//  sec_pulse  out  1       1-cycle pulse on each second advance
//  year/mon/day/hrs/min/sec  out  YEAR_W/4/5/5/6/6  current time/date
// BEHAVIOUR
//  Reset: year=YEAR_RST, mon=1, day=1, hrs=min=sec=0; prescaler=0; sec_pulse=load_err=0;
//   alarm_flag=0; stored alarm time=0:0:0; alarm disabled.
//  Prescaler: when run=1, counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and an internal tick fires.
//  Tick: at the same edge, sec advances; the carry chain ripples within that single edge.
//   sec 59->0 carries into min; min 59->0 carries into hrs; hrs 23->0 carries into day.
//   day==days_in(mon,year)->1 carries into mon; mon 12->1 carries into year+1.
//   year wraps modulo 2^YEAR_W.
//   sec_pulse is registered high for the one cycle in which the new value is visible.
//  days_in: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
//   Feb = 29 if (year%4==0 && year%100!=0) || year%400==0, else 28.
//   Out-of-range mon cannot occur, since loads are validated.
//  Load: sampled on the edge where load=1.
//   Valid when mon is 1..12, day is 1..days_in(ld_mon,ld_year), hrs<=23, min<=59, sec<=59.
//   Valid load: all counters take ld_* at that edge and the prescaler clears to 0.
//   Load beats a coincident tick: the tick is discarded and sec_pulse=0.
//   Load works with run=0.
//   Invalid load: counters are untouched, the tick proceeds normally, and load_err=1 the next cycle.
//  Alarm: al_set latches the alarm time and enable.
//   On any tick-driven update where the new hrs:min:sec equals the stored alarm time and the alarm
//   is enabled, alarm_flag is set. A load never triggers the alarm.
//   alarm_flag stays set until al_ack. If set and ack land in the same cycle, set wins.
//   al_set in the same cycle as a tick compares against the old stored alarm time.
//  rst mid-operation: every register returns to its reset value immediately, including the prescaler.
// TESTING
//  1 CLK_DIV=4: reset, run=1 for 12 cycles -> sec=3; sec_pulse exactly every 4th cycle.
//  2 Load 2023-12-31 23:59:59, one tick -> 2024-01-01 00:00:00; sec_pulse=1, load_err=0.
//  3 Load 2024-02-28 23:59:59, tick -> 02-29. Load 2100-02-28 23:59:59, tick -> 03-01.
//    Load 2000-02-28 23:59:59, tick -> 02-29.
//  4 Load 2023-02-29 and mon=13 -> load_err pulses once each; time/date unchanged and still counting.
//  5 al_set 00:00:05 en=1 after reset; 5 ticks -> alarm_flag=1, held until al_ack.
//    Ack on a cycle that re-matches -> flag stays 1.
//  6 Load asserted on the same cycle as a tick -> loaded values exact, no sec_pulse.
//    rst asserted mid-count -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/rtc_calendar_gen2.sv
// Real-time calendar clock: prescaled 1 Hz advance of sec/min/hrs/day/mon/year with
// Gregorian leap handling, validated load and a sticky daily alarm.
module rtc_calendar_gen2 #(
    parameter int CLK_DIV  = 50_000_000,
    parameter int YEAR_W   = 12,
    parameter int YEAR_RST = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [3:0]        ld_mon,
    input  logic [4:0]        ld_day,
    input  logic [4:0]        ld_hrs,
    input  logic [5:0]        ld_min,
    input  logic [5:0]        ld_sec,
    output logic              load_err,
    input  logic              al_set,
    input  logic [4:0]        al_hrs,
    input  logic [5:0]        al_min,
    input  logic [5:0]        al_sec,
    input  logic              al_en,
    input  logic              al_ack,
    output logic              alarm_flag,
    output logic              sec_pulse,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        mon,
    output logic [4:0]        day,
    output logic [4:0]        hrs,
    output logic [5:0]        min,
    output logic [5:0]        sec
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int unsigned yy;
        yy = 32'(y);
        return ((yy % 32'd4) == 32'd0 && (yy % 32'd100) != 32'd0) || (yy % 32'd400) == 32'd0;
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    logic [PW-1:0]     presc;
    logic              tick;
    logic              ld_ok;
    logic              take_load;
    logic              al_hit;
    logic [4:0]        al_hrs_q;
    logic [5:0]        al_min_q;
    logic [5:0]        al_sec_q;
    logic              al_en_q;

    logic              c_sec, c_min, c_hrs, c_day, c_mon;
    logic [5:0]        n_sec, n_min;
    logic [4:0]        n_hrs, n_day;
    logic [3:0]        n_mon;
    logic [YEAR_W-1:0] n_year;

    // Whole carry chain is evaluated combinationally so a tick settles in one edge.
    always_comb begin
        tick   = run && (presc == PMAX);
        c_sec  = (sec == 6'd59);
        c_min  = c_sec && (min == 6'd59);
        c_hrs  = c_min && (hrs == 5'd23);
        c_day  = c_hrs && (day == days_in(mon, year));
        c_mon  = c_day && (mon == 4'd12);
        n_sec  = c_sec ? '0 : sec + 6'd1;
        n_min  = c_sec ? (c_min ? '0 : min + 6'd1) : min;
        n_hrs  = c_min ? (c_hrs ? '0 : hrs + 5'd1) : hrs;
        n_day  = c_hrs ? (c_day ? 5'd1 : day + 5'd1) : day;
        n_mon  = c_day ? (c_mon ? 4'd1 : mon + 4'd1) : mon;
        n_year = c_mon ? year + YEAR_W'(1) : year;

        ld_ok  = (ld_mon >= 4'd1) && (ld_mon <= 4'd12) &&
                 (ld_day >= 5'd1) && (ld_day <= days_in(ld_mon, ld_year)) &&
                 (ld_hrs <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
        take_load = load && ld_ok;
        al_hit = al_en_q && (n_hrs == al_hrs_q) && (n_min == al_min_q) && (n_sec == al_sec_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            year       <= YEAR_W'(YEAR_RST);
            mon        <= 4'd1;
            day        <= 5'd1;
            hrs        <= '0;
            min        <= '0;
            sec        <= '0;
            sec_pulse  <= 1'b0;
            load_err   <= 1'b0;
            alarm_flag <= 1'b0;
            al_hrs_q   <= '0;
            al_min_q   <= '0;
            al_sec_q   <= '0;
            al_en_q    <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            load_err  <= 1'b0;
            if (take_load) begin
                year  <= ld_year;
                mon   <= ld_mon;
                day   <= ld_day;
                hrs   <= ld_hrs;
                min   <= ld_min;
                sec   <= ld_sec;
                presc <= '0;
            end else begin
                load_err <= load;
                if (run)
                    presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    year      <= n_year;
                    mon       <= n_mon;
                    day       <= n_day;
                    hrs       <= n_hrs;
                    min       <= n_min;
                    sec       <= n_sec;
                    sec_pulse <= 1'b1;
                end
            end

            // Set has priority over ack; compare uses the alarm time stored before this edge.
            if (tick && !take_load && al_hit)
                alarm_flag <= 1'b1;
            else if (al_ack)
                alarm_flag <= 1'b0;

            if (al_set) begin
                al_hrs_q <= al_hrs;
                al_min_q <= al_min;
                al_sec_q <= al_sec;
                al_en_q  <= al_en;
            end
        end
    end

endmodule
